// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, the command master's state
// encoding and the constant protection value driven on AWPROT/ARPROT.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [2:0] AXI_PROT = 3'b000;

  // States in which the master is waiting on the slave and the watchdog runs.
  function automatic logic in_wait(state_e s);
    return (s inside {WR_ADDR, WR_RESP, RD_ADDR, RD_DATA});
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns one command/response handshake into a single
// AXI4-Lite write or read, with a sticky watchdog for unresponsive slaves.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,

  output logic        busy,
  output logic        timeout_err,

  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [2:0]  M_AXI_AWPROT,

  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,

  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,

  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [2:0]  M_AXI_ARPROT,

  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  // Counter just wide enough to hold TIMEOUT_CYCLES; 0 disables the watchdog.
  localparam int              WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam bit              WD_EN    = (TIMEOUT_CYCLES > 0);

  state_e          state;
  logic            aw_done;
  logic            w_done;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_next;

  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic ar_fire;
  logic r_fire;

  assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire  = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_fire  = M_AXI_BVALID  && M_AXI_BREADY;
  assign ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_fire  = M_AXI_RVALID  && M_AXI_RREADY;

  assign wd_next      = wd_cnt + WD_W'(1);
  assign cmd_ready    = (state == IDLE);
  assign M_AXI_AWPROT = AXI_PROT;
  assign M_AXI_ARPROT = AXI_PROT;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      busy          <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            M_AXI_AWADDR <= cmd_addr;
            M_AXI_ARADDR <= cmd_addr;
            M_AXI_WDATA  <= cmd_wdata;
            M_AXI_WSTRB  <= cmd_wstrb;
            busy         <= 1'b1;
            if (cmd_write) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= WR_ADDR;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end

        // AW and W retire independently; B is only accepted once both have.
        WR_ADDR: begin
          if (aw_fire) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_fire) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (b_fire) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp_write    <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end

        RD_ADDR: begin
          if (ar_fire) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (r_fire) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Watchdog only flags; the transaction keeps waiting as AXI requires.
      if (state == IDLE) begin
        if (cmd_valid) wd_cnt <= '0;
      end else if (WD_EN && in_wait(state) && (wd_cnt != WD_LIMIT)) begin
        wd_cnt <= wd_next;
        if (wd_next == WD_LIMIT) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master: AXI4-Lite slave BFM with random
// channel delays, a reference memory model and a response scoreboard.
module tb_axil_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout_err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axil_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .timeout_err(timeout_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_AWPROT(awprot),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_ARPROT(arprot),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_expired(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bounded wait expired before the expected event", name);
  endtask

  // Reference model: memory as seen by commands, plus slave behaviour knobs.
  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] slv_mem [logic [29:0]];
  int          force_resp = -1;
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit          rsp_hold = 1'b0;
  bit          rsp_rand = 1'b0;

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (force_resp >= 0) return force_resp[1:0];
    return a[11:10];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    return slv_mem.exists(a[31:2]) ? slv_mem[a[31:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Slave BFM: decides READY/VALID on the falling edge, so a handshake seen
  // here completes on the following rising edge. Also checks VALID stability.
  initial begin
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0, b_hs = 0, r_pend = 0, r_hs = 0;
    bit          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] aw_prev = '0, w_prev = '0, ar_prev = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        continue;
      end
      if (aw_wait) begin
        check("awvalid_held", awvalid, 1);
        check("awaddr_stable", awaddr, aw_prev);
      end
      if (w_wait) begin
        check("wvalid_held", wvalid, 1);
        check("wdata_stable", wdata, w_prev);
      end
      if (ar_wait) begin
        check("arvalid_held", arvalid, 1);
        check("araddr_stable", araddr, ar_prev);
      end

      if (b_hs) begin
        bvalid = 0; b_hs = 0; b_pend = 0;
      end else if (b_pend && !bvalid) begin
        if (b_cnt >= b_delay) begin
          bvalid = 1;
          bresp  = resp_of(s_awaddr);
        end else b_cnt++;
      end
      if (bvalid && bready) b_hs = 1;

      if (r_hs) begin
        rvalid = 0; r_hs = 0; r_pend = 0;
      end else if (r_pend && !rvalid) begin
        if (r_cnt >= r_delay) begin
          rvalid = 1;
          rdata  = slv_read(s_araddr);
          rresp  = resp_of(s_araddr);
        end else r_cnt++;
      end
      if (rvalid && rready) r_hs = 1;

      if (awvalid) begin
        awready = (aw_cnt >= aw_delay);
        aw_cnt++;
        if (awready) begin s_awaddr = awaddr; aw_got = 1; end
      end else begin
        awready = 0; aw_cnt = 0;
      end
      aw_wait = awvalid && !awready;
      aw_prev = awaddr;

      if (wvalid) begin
        wready = (w_cnt >= w_delay);
        w_cnt++;
        if (wready) begin s_wdata = wdata; s_wstrb = wstrb; w_got = 1; end
      end else begin
        wready = 0; w_cnt = 0;
      end
      w_wait = wvalid && !wready;
      w_prev = wdata;

      if (aw_got && w_got) begin
        slv_mem[s_awaddr[31:2]] = merge(slv_read(s_awaddr), s_wdata, s_wstrb);
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
      end

      if (arvalid) begin
        arready = (ar_cnt >= ar_delay);
        ar_cnt++;
        if (arready) begin s_araddr = araddr; r_pend = 1; r_cnt = 0; end
      end else begin
        arready = 0; ar_cnt = 0;
      end
      ar_wait = arvalid && !arready;
      ar_prev = araddr;
    end
  end

  // Response monitor: drives rsp_ready and scores every accepted response.
  initial begin
    rsp_t e;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rsp_ready = 0;
        continue;
      end
      rsp_ready = rsp_hold ? 1'b0 : (rsp_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rsp_unexpected: got response rdata=0x%08h with no command pending",
                   rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rsp_write", rsp_write, e.write);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", rsp_resp, e.resp);
        end
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL global_timeout: simulation did not complete, got %0d errors", n_err);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (!cmd_ready) begin
      tick(1);
      if (++budget > 200) begin wait_expired("cmd_ready"); break; end
    end
  endtask

  // Pushes the expected response, then holds the command until accepted.
  // Returns at the falling edge of the first cycle after acceptance.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    rsp_t e;
    e.write = wr;
    e.resp  = resp_of(a);
    if (wr) begin
      ref_mem[a[31:2]] = merge(ref_read(a), d, s);
      e.rdata = 32'h0;
    end else begin
      e.rdata = ref_read(a);
    end
    exp_q.push_back(e);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    wait_ready();
    tick(1);
    cmd_valid = 0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 || !cmd_ready) begin
      tick(1);
      if (++budget > 300) begin wait_expired("drain"); break; end
    end
  endtask

  initial begin
    resetn = 0; cmd_valid = 0; cmd_write = 0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    tick(3);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_awaddr", awaddr, 0);
    resetn = 1;
    tick(1);

    // Zero-wait write
    issue(1, 32'h08, 32'h1234_5678, 4'hF);
    check("zw_aw_c1", awvalid, 1);
    check("zw_w_c1", wvalid, 1);
    check("zw_awaddr", awaddr, 32'h08);
    check("zw_wdata", wdata, 32'h1234_5678);
    check("zw_busy", busy, 1);
    check("zw_cmd_ready", cmd_ready, 0);
    tick(1);
    check("zw_bready_c2", bready, 1);
    check("zw_aw_c2", awvalid, 0);
    check("zw_rsp_c2", rsp_valid, 0);
    tick(1);
    check("zw_rsp_c3", rsp_valid, 1);
    wait_drain();

    // Skewed write: W handshakes at cycle 1, AW at cycle 5
    aw_delay = 4;
    issue(1, 32'h40C, 32'hA5A5_0F0F, 4'b0101);
    check("sk_w_c1", wvalid, 1);
    for (int k = 2; k <= 5; k++) begin
      tick(1);
      check("sk_w_low", wvalid, 0);
      check("sk_aw_held", awvalid, 1);
      check("sk_awaddr", awaddr, 32'h40C);
      check("sk_bready_low", bready, 0);
    end
    tick(1);
    check("sk_bready_c6", bready, 1);
    check("sk_aw_c6", awvalid, 0);
    wait_drain();
    aw_delay = 0;

    // Read with late data and DECERR
    ref_mem[30'h4] = 32'hDEAD_BEEF;
    slv_mem[30'h4] = 32'hDEAD_BEEF;
    force_resp = 3;
    r_delay = 4;
    issue(0, 32'h10, 32'h0, 4'h0);
    check("rd_ar_c1", arvalid, 1);
    check("rd_araddr", araddr, 32'h10);
    tick(1);
    check("rd_rready_c2", rready, 1);
    check("rd_ar_c2", arvalid, 0);
    wait_drain();
    force_resp = -1;
    r_delay = 0;

    // Response backpressure
    rsp_hold = 1;
    issue(0, 32'h10, 32'h0, 4'h0);
    for (int k = 0; k < 10 && !rsp_valid; k++) tick(1);
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("bp_resp", rsp_resp, 0);
      check("bp_write", rsp_write, 0);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_busy", busy, 1);
      tick(1);
    end
    rsp_hold = 0;
    begin
      int budget = 0;
      while (rsp_valid) begin
        tick(1);
        if (++budget > 5) begin wait_expired("bp_release"); break; end
      end
    end
    check("bp_cmd_ready_after", cmd_ready, 1);
    check("bp_busy_after", busy, 0);

    // Randomized traffic against the reference memory
    rsp_rand = 1;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      wait_ready();
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
      issue($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
    end
    wait_drain();
    rsp_rand = 0;
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    check("no_timeout_yet", timeout_err, 0);

    // Watchdog: BVALID withheld past TIMEOUT_CYCLES
    b_delay = 30;
    issue(1, 32'h20, 32'hCAFE_F00D, 4'hF);
    tick(15);
    check("to_c16", timeout_err, 0);
    tick(1);
    check("to_c17", timeout_err, 1);
    check("to_bready", bready, 1);
    wait_drain();
    check("to_sticky", timeout_err, 1);
    b_delay = 0;

    // Mid-transaction reset with ARVALID pending
    ar_delay = 100;
    issue(0, 32'h30, 32'h0, 4'h0);
    tick(2);
    check("mr_ar_pending", arvalid, 1);
    resetn = 0;
    tick(1);
    check("mr_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_timeout", timeout_err, 0);
    check("mr_busy", busy, 0);
    exp_q.delete();
    ar_delay = 0;
    tick(1);
    resetn = 1;
    tick(1);
    check("mr_cmd_ready", cmd_ready, 1);
    issue(1, 32'h30, 32'h0BAD_F00D, 4'b1100);
    wait_drain();
    issue(0, 32'h30, 32'h0, 4'h0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite initiator that converts a single-outstanding command/response handshake into AXI4-Lite write or read transactions. It is the master-side counterpart of the register-file slaves in the emulator, including the ABM-manager config block. Local sequencers use it to program and poll any AXI4-Lite slave without building channel logic. It also includes a watchdog that flags slaves that never respond.

## Interface
- `TIMEOUT_CYCLES`, default 1024: number of cycles without a B/R response before `timeout_err` sets. 0 disables the watchdog.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block is idle and can accept a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: byte address.
- `cmd_wdata` in 32: write data, ignored for reads.
- `cmd_wstrb` in 4: write strobes, ignored for reads.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_write` out 1: echoes `cmd_write` of the completed command.
- `rsp_rdata` out 32: read data. Zero for writes.
- `rsp_resp` out 2: BRESP or RRESP of the transaction.
- `busy` out 1: high from command accept until response accept.
- `timeout_err` out 1: sticky watchdog flag. Cleared only by reset.
- `M_AXI_AWADDR` out 32, `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1, `M_AXI_AWPROT` out 3 (constant 0).
- `M_AXI_WDATA` out 32, `M_AXI_WSTRB` out 4, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1.
- `M_AXI_ARADDR` out 32, `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1, `M_AXI_ARPROT` out 3 (constant 0).
- `M_AXI_RDATA` in 32, `M_AXI_RRESP` in 2, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1.

## Operation
- One transaction is outstanding at a time. All outputs are registered except `cmd_ready`, which is `state==IDLE`.
- **Reset:** state IDLE; all VALID/READY outputs, `rsp_valid`, `timeout_err` and the watchdog counter are 0. Address, data and response registers are 0.
- **IDLE:** on `cmd_valid && cmd_ready`, latch addr, wdata, wstrb and write into the AW/W/AR output registers.
  - If the command is a write: raise AWVALID and WVALID, clear `aw_done`/`w_done`, go to WR_ADDR.
  - If the command is a read: raise ARVALID, go to RD_ADDR.
- **WR_ADDR:**
  - AW handshake (AWVALID & AWREADY): drop AWVALID and set `aw_done`.
  - W handshake: drop WVALID and set `w_done`.
  - AW and W complete independently, in either order or in the same cycle.
  - Once both are done, or complete this cycle, raise BREADY and go to WR_RESP.
- **WR_RESP:** on BVALID & BREADY, drop BREADY, capture BRESP into `rsp_resp`, set `rsp_rdata`=0 and `rsp_write`=1, raise `rsp_valid`, go to RSP.
- **RD_ADDR:** on AR handshake, drop ARVALID, raise RREADY, go to RD_DATA.
- **RD_DATA:** on RVALID & RREADY, drop RREADY, capture RDATA and RRESP, set `rsp_write`=0, raise `rsp_valid`, go to RSP.
- **RSP:** hold all `rsp_*` stable until `rsp_ready`. On `rsp_ready`, drop `rsp_valid` and return to IDLE.
- **Watchdog:**
  - The counter clears on command accept and increments each cycle in WR_ADDR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches `TIMEOUT_CYCLES`, set `timeout_err` and saturate the counter.
  - The transaction is not abandoned; the FSM keeps waiting, as AXI requires.
- `busy` = `state != IDLE`.

## Timing
- Best-case write with all slave READYs high:
  - Accept at cycle 0.
  - AWVALID/WVALID high in cycle 1, handshake in cycle 1.
  - BREADY high in cycle 2, B handshake in cycle 2 if BVALID is high.
  - `rsp_valid` high in cycle 3.
- Best-case read: accept at 0, ARVALID at 1, RREADY at 2, `rsp_valid` at 3.
- VALID never drops before its handshake. Address and data remain stable while VALID is high.
- `cmd_ready` is low from the cycle after accept until the cycle after the `rsp_ready` handshake. Back-to-back commands therefore have at least one idle cycle between them.
- A BVALID or RVALID arriving before BREADY or RREADY is legal and is held by the slave; the block takes no special action.
- A reset asserted mid-transaction forces IDLE with all outputs deasserted on the next edge. The system resets the slave together with this block.

## Structure
- Shared package `axil_pkg`: response codes OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3, and the state encoding IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- Single module, no sub-modules.

## Test plan
- **Zero-wait write:** write 0x12345678 to 0x08, strb 0xF, with all READYs high. Expect AW/W at cycle 1, `rsp_valid` at cycle 3, `rsp_resp`=0, `rsp_write`=1.
- **Skewed write:** WREADY at cycle 1, AWREADY delayed to cycle 5. Expect WVALID low from cycle 2, AWVALID held with stable AWADDR until cycle 5, BREADY rising at cycle 6.
- **Read with late data:** read 0x10 with RVALID delayed 4 cycles, RDATA=0xDEADBEEF, RRESP=3. Expect `rsp_rdata`=0xDEADBEEF, `rsp_resp`=3, `rsp_write`=0.
- **Response backpressure:** hold `rsp_ready` low for 10 cycles. Expect `rsp_*` stable, `cmd_ready`=0, `busy`=1. After release, `cmd_ready`=1 on the following cycle.
- **Timeout:** with `TIMEOUT_CYCLES`=16 and BVALID never asserted, expect `timeout_err`=1 after 16 waiting cycles while BREADY stays high. A late BVALID then completes normally and `timeout_err` remains 1.
- **Mid-transaction reset:** pulse `resetn` low with ARVALID pending. Expect all VALID/READY outputs, `rsp_valid` and `timeout_err` at 0, and `cmd_ready`=1 after release.
